cache_line_fill: RTL and testbench

//  Parametrised instruction-cache line-fill buffer.
//  - Assembles WORDS_PER_LINE memory words into one cache line using a valid/ready word handshake.
//  - Supports critical-word-first wrap ordering and abort.
//  - Hands the completed line and its address to the cache array through a valid/ready handshake.
//  - Sits between the instruction-memory read port and the I-cache data/tag arrays.

---
 rtl/cache_line_fill.sv | 137 +++++++++++++
 tb/tb_cache_line_fill.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill.sv
// Instruction-cache line-fill buffer: gathers WORDS_PER_LINE words (critical-word-first wrap) into one line.
// Optional critical-word forwarding is compiled in when FILL_CRIT_FWD_EN is defined.
module cache_line_fill #(
  parameter  int WORD_W         = 32,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int ADDR_W         = 32,
  localparam int OFF_W          = $clog2(WORDS_PER_LINE),
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE
) (
  input  logic                      i_clk,
  input  logic                      i_clr_n,
  input  logic                      i_start,
  input  logic [ADDR_W-1:0]         i_start_addr,
  input  logic [OFF_W-1:0]          i_start_offset,
  input  logic                      i_abort,
  input  logic [WORD_W-1:0]         i_word_data,
  input  logic                      i_word_valid,
  output logic                      o_word_ready,
  output logic                      o_busy,
  output logic [WORDS_PER_LINE-1:0] o_word_mask,
  output logic [LINE_W-1:0]         o_line_data,
  output logic [ADDR_W-1:0]         o_line_addr,
  output logic                      o_line_valid,
  input  logic                      i_line_ready,
  output logic                      o_crit_valid,
  output logic [WORD_W-1:0]         o_crit_data,
  output logic [1:0]                o_dbg_state
);

  localparam int CNT_W = OFF_W + 1;

  // Handshakes: a word moves when i_word_valid && o_word_ready on one rising edge;
  // a line moves when o_line_valid && i_line_ready. Ready/valid outputs decode from state only.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LINE_W-1:0]       r_line_data;
  logic [ADDR_W-1:0]       r_line_addr;
  logic [WORDS_PER_LINE-1:0] r_word_mask;
  logic [OFF_W-1:0]        r_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    w_in_fill;
  logic                    w_abort;
  logic                    w_xfer;
  logic                    w_last;

  // Abort wins over a same-cycle word, so the word is simply not a transfer.
  assign w_in_fill = (r_state == S_FILL);
  assign w_abort   = i_abort && w_in_fill;
  assign w_xfer    = i_word_valid && w_in_fill && !i_abort;
  assign w_last    = w_xfer && (r_count == CNT_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_FILL;
      S_FILL: begin
        if (w_abort)     w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: if (i_line_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_line_data <= '0;
      r_line_addr <= '0;
      r_word_mask <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_line_addr <= i_start_addr;
        r_ptr       <= i_start_offset;
        r_word_mask <= '0;
        r_count     <= '0;
      end
      if (w_abort) begin
        r_word_mask <= '0;
      end else if (w_xfer) begin
        // Word k lives at the MSB end for k=0; ptr wraps naturally at OFF_W bits.
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
          if (r_ptr == OFF_W'(k)) r_line_data[LINE_W-1-k*WORD_W -: WORD_W] <= i_word_data;
        end
        r_word_mask[r_ptr] <= 1'b1;
        r_ptr              <= r_ptr + OFF_W'(1);
        r_count            <= r_count + CNT_W'(1);
      end
    end
  end

`ifdef FILL_CRIT_FWD_EN
  logic              r_crit_valid;
  logic [WORD_W-1:0] r_crit_data;

  // First accepted word of a fill is the critical one; pulse for one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      r_crit_valid <= 1'b0;
      if (w_xfer && (r_count == '0)) begin
        r_crit_valid <= 1'b1;
        r_crit_data  <= i_word_data;
      end
    end
  end

  assign o_crit_valid = r_crit_valid;
  assign o_crit_data  = r_crit_data;
`else
  assign o_crit_valid = 1'b0;
  assign o_crit_data  = '0;
`endif

  assign o_word_ready = (r_state == S_FILL);
  assign o_busy       = (r_state != S_IDLE);
  assign o_line_valid = (r_state == S_DONE);
  assign o_word_mask  = r_word_mask;
  assign o_line_data  = r_line_data;
  assign o_line_addr  = r_line_addr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: directed and randomized fills against a word-array reference model.
module tb_cache_line_fill;

  localparam int W = 32, N = 4, AW = 32, OW = 2, LW = W * N;
  localparam int W2 = 16, N2 = 8, OW2 = 3, LW2 = W2 * N2;
`ifdef FILL_CRIT_FWD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n, start, abort, word_valid, word_ready, busy, line_valid, line_ready, crit_valid;
  logic [AW-1:0] start_addr, line_addr;
  logic [OW-1:0] start_offset;
  logic [W-1:0]  word_data, crit_data;
  logic [N-1:0]  word_mask;
  logic [LW-1:0] line_data;
  logic [1:0]    dbg_state;

  logic b_start, b_abort, b_word_valid, b_word_ready, b_busy, b_line_valid, b_line_ready, b_crit_valid;
  logic [AW-1:0]  b_start_addr, b_line_addr;
  logic [OW2-1:0] b_start_offset;
  logic [W2-1:0]  b_word_data, b_crit_data;
  logic [N2-1:0]  b_word_mask;
  logic [LW2-1:0] b_line_data;
  logic [1:0]     b_dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_words [N];
  logic [N-1:0] m_mask;
  logic [AW-1:0] m_addr;
  int m_ptr, m_cnt;

  always #5 clk = ~clk;

  cache_line_fill #(.WORD_W(W), .WORDS_PER_LINE(N), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_start(start), .i_start_addr(start_addr),
    .i_start_offset(start_offset), .i_abort(abort), .i_word_data(word_data),
    .i_word_valid(word_valid), .o_word_ready(word_ready), .o_busy(busy),
    .o_word_mask(word_mask), .o_line_data(line_data), .o_line_addr(line_addr),
    .o_line_valid(line_valid), .i_line_ready(line_ready), .o_crit_valid(crit_valid),
    .o_crit_data(crit_data), .o_dbg_state(dbg_state));

  cache_line_fill #(.WORD_W(W2), .WORDS_PER_LINE(N2), .ADDR_W(AW)) dut_b (
    .i_clk(clk), .i_clr_n(clr_n), .i_start(b_start), .i_start_addr(b_start_addr),
    .i_start_offset(b_start_offset), .i_abort(b_abort), .i_word_data(b_word_data),
    .i_word_valid(b_word_valid), .o_word_ready(b_word_ready), .o_busy(b_busy),
    .o_word_mask(b_word_mask), .o_line_data(b_line_data), .o_line_addr(b_line_addr),
    .o_line_valid(b_line_valid), .i_line_ready(b_line_ready), .o_crit_valid(b_crit_valid),
    .o_crit_data(b_crit_data), .o_dbg_state(b_dbg_state));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] m_line();
    logic [LW-1:0] l;
    for (int k = 0; k < N; k++) l[LW-1-k*W -: W] = m_words[k];
    return l;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_words[k] = '0;
    m_mask = '0; m_addr = '0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] addr, input int off, input bit with_abort);
    start = 1'b1; start_addr = addr; start_offset = OW'(off); abort = with_abort;
    step();
    start = 1'b0; abort = 1'b0;
    m_addr = addr; m_ptr = off; m_cnt = 0; m_mask = '0;
    chk("start_busy", busy, 1'b1);
    chk("start_ready", word_ready, 1'b1);
    chk("start_mask", word_mask, 0);
    chk("start_lvalid", line_valid, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] data, input int gap);
    bit first;
    for (int g = 0; g < gap; g++) begin
      word_valid = 1'b0; word_data = $urandom;
      step();
      chk("stall_mask", word_mask, m_mask);
      chk("stall_ready", word_ready, 1'b1);
    end
    word_valid = 1'b1; word_data = data;
    step();
    word_valid = 1'b0; word_data = $urandom;
    first = (m_cnt == 0);
    m_words[m_ptr] = data; m_mask[m_ptr] = 1'b1;
    m_ptr = (m_ptr + 1) % N; m_cnt++;
    chk("word_mask", word_mask, m_mask);
    chk("line_valid_after_word", line_valid, m_cnt == N);
    chk("ready_after_word", word_ready, m_cnt != N);
    chk("crit_valid", crit_valid, CRIT && first);
    if (CRIT && first) chk("crit_data", crit_data, data);
  endtask

  task automatic check_line();
    chk("line_data", line_data, m_line());
    chk("line_addr", line_addr, m_addr);
  endtask

  task automatic consume(input int delay);
    for (int i = 0; i < delay; i++) begin
      start = (i == 1); start_addr = 32'hFFFF_0000; start_offset = OW'(1);
      abort = (i == 2);
      step();
      start = 1'b0; abort = 1'b0;
      chk("hold_lvalid", line_valid, 1'b1);
      chk("hold_busy", busy, 1'b1);
      chk("hold_ready", word_ready, 1'b0);
      chk("hold_mask", word_mask, {N{1'b1}});
      check_line();
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    chk("release_lvalid", line_valid, 1'b0);
    chk("release_busy", busy, 1'b0);
    chk("release_ready", word_ready, 1'b0);
  endtask

  task automatic full_fill(input logic [AW-1:0] addr, input int off, input int max_gap, input int delay);
    do_start(addr, off, 1'b0);
    for (int i = 0; i < N; i++) send_word($urandom, $urandom_range(0, max_gap));
    check_line();
    consume(delay);
  endtask

  task automatic check_reset_values();
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", word_ready, 1'b0);
    chk("rst_lvalid", line_valid, 1'b0);
    chk("rst_mask", word_mask, 0);
    chk("rst_data", line_data, 0);
    chk("rst_addr", line_addr, 0);
    chk("rst_cvalid", crit_valid, 1'b0);
    chk("rst_cdata", crit_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W2-1:0] bw [N2];
    logic [N2-1:0] bmask;
    logic [LW2-1:0] bline;
    int bptr;

    clr_n = 1'b0; start = 1'b0; start_addr = '0; start_offset = '0; abort = 1'b0;
    word_data = '0; word_valid = 1'b0; line_ready = 1'b0;
    b_start = 1'b0; b_start_addr = '0; b_start_offset = '0; b_abort = 1'b0;
    b_word_data = '0; b_word_valid = 1'b0; b_line_ready = 1'b0;
    model_reset();
    step(); step();
    clr_n = 1'b1;
    check_reset_values();

    // Ordered fill, with an IDLE-time abort that must be ignored.
    do_start(32'h1000, 0, 1'b1);
    send_word(32'hA0, 0); send_word(32'hA1, 0); send_word(32'hA2, 0); send_word(32'hA3, 0);
    chk("ordered_line", line_data, 128'h000000A0_000000A1_000000A2_000000A3);
    check_line();
    consume(1);

    // Wrap fill starting at word 2.
    do_start(32'h2040, 2, 1'b0);
    send_word(32'hB2, 0); send_word(32'hB3, 0); send_word(32'hB0, 0); send_word(32'hB1, 0);
    chk("wrap_line", line_data, 128'h000000B0_000000B1_000000B2_000000B3);
    check_line();
    consume(0);

    // Stalls of 3 cycles and 5 cycles of line backpressure.
    do_start(32'h3000, 1, 1'b0);
    for (int i = 0; i < N; i++) send_word($urandom, 3);
    check_line();
    consume(5);

    // line_ready already high when the line completes: one-cycle DONE.
    do_start(32'h3100, 3, 1'b0);
    for (int i = 0; i < N - 1; i++) send_word($urandom, 0);
    line_ready = 1'b1;
    send_word($urandom, 0);
    check_line();
    step();
    line_ready = 1'b0;
    chk("early_ready_lvalid", line_valid, 1'b0);
    chk("early_ready_busy", busy, 1'b0);

    // Abort after 2 words, with a word offered in the abort cycle.
    do_start(32'h4000, 0, 1'b0);
    send_word(32'hC0, 0); send_word(32'hC1, 0);
    abort = 1'b1; word_valid = 1'b1; word_data = 32'hDEAD_BEEF;
    step();
    abort = 1'b0; word_valid = 1'b0;
    m_mask = '0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_state", dbg_state, 0);
    chk("abort_mask", word_mask, 0);
    chk("abort_cvalid", crit_valid, 1'b0);
    check_line();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_lvalid", line_valid, 1'b0);
    end
    full_fill(32'h4100, 2, 1, 1);

    // Reset after 3 words discards the partial line.
    do_start(32'h5000, 1, 1'b0);
    for (int i = 0; i < 3; i++) send_word($urandom, 0);
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    model_reset();
    check_reset_values();
    full_fill(32'h5100, 0, 0, 2);

    // Randomized fills.
    for (int r = 0; r < 25; r++)
      full_fill($urandom, $urandom_range(0, N - 1), $urandom_range(0, 3), $urandom_range(0, 4));

    // 8-word, 16-bit line filled from offset 7.
    for (int k = 0; k < N2; k++) bw[k] = '0;
    bmask = '0;
    b_start = 1'b1; b_start_addr = 32'hBEEF0; b_start_offset = 3'd7;
    step();
    b_start = 1'b0;
    bptr = 7;
    chk("b_start_busy", b_busy, 1'b1);
    for (int i = 0; i < N2; i++) begin
      b_word_valid = 1'b1; b_word_data = W2'($urandom);
      bw[bptr] = b_word_data;
      step();
      b_word_valid = 1'b0;
      bmask[bptr] = 1'b1;
      bptr = (bptr + 1) % N2;
      chk("b_mask", b_word_mask, bmask);
      chk("b_lvalid", b_line_valid, i == N2 - 1);
    end
    for (int k = 0; k < N2; k++) bline[LW2-1-k*W2 -: W2] = bw[k];
    chk("b_line", b_line_data, bline);
    chk("b_addr", b_line_addr, 32'hBEEF0);
    b_line_ready = 1'b1;
    step();
    b_line_ready = 1'b0;
    chk("b_release", b_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
